// File: rtl/riscv_pkg.sv
// Shared pipeline definitions for the data-memory access path.
package riscv_pkg;

  // MEM-stage access sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } dmem_state_t;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 16;

  // Byte-offset bits that must be zero for a word-aligned address.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Saturating bus-timeout counter: clear has priority over enable.
// hit_o is asserted once the count has reached LIMIT-1.
module dmem_timeout_cnt #(
  parameter  int unsigned LIMIT = 16,
  localparam int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic hit_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment until saturated at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // >= rather than == so a grant on the last REQ cycle still leaves the
  // following WAIT cycle bounded once the count has moved past LIMIT-1.
  assign hit_o = (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller (word lw/sw only).
// Sequences IDLE -> REQ -> WAIT -> DONE over a req/gnt/rvalid port, stalls
// the pipeline until the access completes and aborts on bus timeout.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses skip the bus and
// pulse misalign_o; otherwise the address is forced word-aligned.
module dmem_access_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  output logic              bus_err_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i
);

  dmem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;

  logic access;
  logic to_hit;
  logic cnt_clear;
  logic cnt_en;

  assign access    = mem_read_i | mem_write_i;
  assign cnt_clear = (state_q == IDLE);
  assign cnt_en    = (state_q == REQ) || (state_q == WAIT);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(addr_i[1:0] & WORD_ALIGN_MASK);
`endif

  dmem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .hit_o   (to_hit)
  );

  // Next-state, request latches and completion status.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    err_d       = err_q;
    mis_d       = mis_q;
    load_data_d = load_data_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = mem_write_i;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          state_d = REQ;
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          state_d = WAIT;
        end else if (to_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) load_data_d = '0;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = DONE;
          if (!we_q) load_data_d = dmem_rdata_i;
        end else if (to_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) load_data_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      load_data_q <= load_data_d;
    end
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign stall_o = ~reset & (((state_q == IDLE) & access) |
                             (state_q == REQ) | (state_q == WAIT));

  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_wdata_o = wdata_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = (state_q == DONE) & ~we_q & ~err_q & ~mis_q;
  assign bus_err_o    = (state_q == DONE) & err_q;

`ifdef MISALIGN_TRAP_EN
  assign misalign_o  = (state_q == DONE) & mis_q;
  assign dmem_addr_o = addr_q;
`else
  assign misalign_o  = 1'b0;
  assign dmem_addr_o = {addr_q[ADDR_W-1:2], addr_q[1:0] & ~WORD_ALIGN_MASK};
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: directed accesses against a configurable
// memory responder, with request and completion scoreboards.
module tb_dmem_access_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        lv;
    logic        be;
    logic        mis;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_i, mem_write_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, load_valid_o, bus_err_o, misalign_o;
  logic [31:0] load_data_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int checks   = 0;
  int failures = 0;

  req_t req_q[$];
  rsp_t rsp_q[$];

  // Responder configuration
  int          gnt_dly   = 0;
  int          rv_dly    = 0;
  bit          never_gnt = 1'b0;
  bit          never_rv  = 1'b0;
  logic [31:0] rdata_cfg = '0;

  dmem_access_ctrl #(
    .TIMEOUT_CYCLES (16),
    .ADDR_W         (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .load_data_o   (load_data_o),
    .load_valid_o  (load_valid_o),
    .bus_err_o     (bus_err_o),
    .misalign_o    (misalign_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_req(input logic we, input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic exp_rsp(input logic lv, input logic be, input logic mis, input logic [31:0] d);
    rsp_t r;
    r.lv = lv; r.be = be; r.mis = mis; r.data = d;
    rsp_q.push_back(r);
  endtask

  // Memory model: grant after gnt_dly request cycles, respond rv_dly cycles later.
  initial begin
    int reqc = 0;
    int wcnt = 0;
    bit pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'hBAD0_BAD0;
      if (pend) begin
        if (wcnt == rv_dly) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = rdata_cfg;
          pend          = 1'b0;
        end else begin
          wcnt++;
        end
      end
      if (dmem_req_o) begin
        if (!never_gnt && reqc == gnt_dly) begin
          dmem_gnt_i = 1'b1;
          if (!never_rv) begin
            pend = 1'b1;
            wcnt = 0;
          end
        end
        reqc++;
      end else begin
        reqc = 0;
      end
    end
  end

  // Request monitor: every REQ cycle must present the expected, stable request.
  initial begin
    bit   req_prev = 1'b0;
    req_t exp;
    forever begin
      @(negedge clk);
      if (!reset && dmem_req_o) begin
        if (req_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_unexpected: got we=%b addr=%h wdata=%h expected no request",
                   dmem_we_o, dmem_addr_o, dmem_wdata_o);
        end else begin
          exp = req_q[0];
          chk("req", {dmem_we_o, dmem_addr_o, dmem_wdata_o}, exp);
        end
      end else if (req_prev && req_q.size() != 0) begin
        void'(req_q.pop_front());
      end
      req_prev = dmem_req_o;
    end
  end

  // Completion monitor: any DONE pulse is matched against the next expectation.
  initial begin
    rsp_t exp;
    forever begin
      @(negedge clk);
      if (!reset && (load_valid_o || bus_err_o || misalign_o)) begin
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got lv=%b be=%b mis=%b data=%h expected no completion",
                   load_valid_o, bus_err_o, misalign_o, load_data_o);
        end else begin
          exp = rsp_q.pop_front();
          chk("rsp", {load_valid_o, bus_err_o, misalign_o, load_data_o}, exp);
        end
      end
    end
  end

  // Issue one access and count stall cycles until it completes (ends in DONE).
  task automatic run_access(input string nm, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int gd, input int rvd, input logic [31:0] rdat,
                            input bit ng, input bit nr, input int exp_stall);
    int sc = 0;
    int n  = 0;
    @(posedge clk);
    #1;
    mem_read_i  = rd;
    mem_write_i = wr;
    addr_i      = a;
    wdata_i     = wd;
    gnt_dly     = gd;
    rv_dly      = rvd;
    rdata_cfg   = rdat;
    never_gnt   = ng;
    never_rv    = nr;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (stall_o) sc++;
      else break;
    end
    chk({nm, "_stall"}, sc, exp_stall);
  endtask

  task automatic go_idle(input int n);
    @(posedge clk);
    #1;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    mem_read_i    = 1'b0;
    mem_write_i   = 1'b0;
    addr_i        = '0;
    wdata_i       = '0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
                       load_data_o, load_valid_o, bus_err_o, misalign_o}, '0);
    reset = 1'b0;

    // Minimum-latency load
    exp_req(1'b0, 32'h100, 32'h1111_1111);
    exp_rsp(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    run_access("load_min", 1, 0, 32'h100, 32'h1111_1111, 0, 0, 32'hDEAD_BEEF, 0, 0, 3);
    go_idle(1);

    // Store with grant delayed 4 cycles: 5 REQ cycles, no completion pulse
    exp_req(1'b1, 32'h204, 32'h1234_5678);
    run_access("store_gdly", 0, 1, 32'h204, 32'h1234_5678, 4, 0, 32'h0, 0, 0, 7);
    go_idle(1);
    chk("ld_hold_store", load_data_o, 32'hDEAD_BEEF);

    // Load with no grant: 16 REQ cycles then bus error, data forced to 0
    exp_req(1'b0, 32'h180, 32'h0);
    exp_rsp(1'b0, 1'b1, 1'b0, 32'h0);
    run_access("load_timeout", 1, 0, 32'h180, 32'h0, 0, 0, 32'h0, 1, 0, 17);
    go_idle(1);
    chk("ld_zero_after_to", load_data_o, 32'h0);

    // Normal load after the timeout
    exp_req(1'b0, 32'h184, 32'h0);
    exp_rsp(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
    run_access("load_recover", 1, 0, 32'h184, 32'h0, 1, 2, 32'hCAFE_F00D, 0, 0, 6);
    go_idle(1);

    // Grant on the last REQ cycle wins over the timeout
    exp_req(1'b0, 32'h188, 32'h0);
    exp_rsp(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    run_access("gnt_at_limit", 1, 0, 32'h188, 32'h0, 15, 0, 32'h0BAD_F00D, 0, 0, 18);
    go_idle(1);

    // rvalid on the timeout cycle of WAIT wins: store completes silently
    exp_req(1'b1, 32'h20C, 32'h55AA_55AA);
    run_access("rv_at_limit", 0, 1, 32'h20C, 32'h55AA_55AA, 0, 14, 32'h0, 0, 0, 17);
    go_idle(1);

    // Store never acknowledged: timeout in WAIT, load data untouched
    exp_req(1'b1, 32'h210, 32'h0F00_0F00);
    exp_rsp(1'b0, 1'b1, 1'b0, 32'h0BAD_F00D);
    run_access("store_timeout", 0, 1, 32'h210, 32'h0F00_0F00, 0, 0, 32'h0, 0, 1, 17);
    go_idle(1);

    // Back-to-back loads
    exp_req(1'b0, 32'h10, 32'h0);
    exp_rsp(1'b1, 1'b0, 1'b0, 32'h1010_1010);
    exp_req(1'b0, 32'h14, 32'h0);
    exp_rsp(1'b1, 1'b0, 1'b0, 32'h1414_1414);
    run_access("b2b_first", 1, 0, 32'h10, 32'h0, 0, 0, 32'h1010_1010, 0, 0, 3);
    run_access("b2b_second", 1, 0, 32'h14, 32'h0, 0, 0, 32'h1414_1414, 0, 0, 3);
    go_idle(2);
    chk("ld_b2b_final", load_data_o, 32'h1414_1414);

    // Misaligned load
`ifdef MISALIGN_TRAP_EN
    exp_rsp(1'b0, 1'b0, 1'b1, 32'h1414_1414);
    run_access("mis_trap", 1, 0, 32'h102, 32'h0, 0, 0, 32'h0F0F_0F0F, 0, 0, 1);
    go_idle(1);
    chk("ld_after_mis", load_data_o, 32'h1414_1414);
`else
    exp_req(1'b0, 32'h100, 32'h0);
    exp_rsp(1'b1, 1'b0, 1'b0, 32'h0F0F_0F0F);
    run_access("mis_align", 1, 0, 32'h102, 32'h0, 0, 0, 32'h0F0F_0F0F, 0, 0, 3);
    go_idle(1);
`endif

    // Read+write together issues a write; reset in WAIT aborts it
    exp_req(1'b1, 32'h300, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    mem_read_i  = 1'b1;
    mem_write_i = 1'b1;
    addr_i      = 32'h300;
    wdata_i     = 32'hA5A5_A5A5;
    gnt_dly     = 0;
    rv_dly      = 2;
    rdata_cfg   = 32'h7777_0000;
    never_gnt   = 1'b0;
    never_rv    = 1'b0;
    @(posedge clk);  // REQ
    @(posedge clk);  // WAIT
    @(negedge clk);
    chk("rw_wait_stall", {stall_o, dmem_req_o, dmem_we_o}, 3'b101);
    reset = 1'b1;
    #1;
    chk("reset_midaccess", {stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
                            load_data_o, load_valid_o, bus_err_o, misalign_o}, '0);
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", {stall_o, dmem_req_o, load_valid_o, bus_err_o, load_data_o}, '0);

    // Normal access after reset
    exp_req(1'b0, 32'h40, 32'h0);
    exp_rsp(1'b1, 1'b0, 1'b0, 32'h7777_7777);
    run_access("load_post_reset", 1, 0, 32'h40, 32'h0, 0, 0, 32'h7777_7777, 0, 0, 3);
    go_idle(2);

    chk("req_q_drained", req_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
